// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus: encoder phases and control in, count and strobes out.
interface quad_decoder_if #(
  parameter int WIDTH = 4
);
  logic             a;
  logic             b;
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic             m;
  logic             step;
  logic             err;
  logic             err_flag;

  modport master (
    output a, b, en, ld, d, clr_err,
    input  q, m, step, err, err_flag
  );

  modport slave (
    input  a, b, en, ld, d, clr_err,
    output q, m, step, err, err_flag
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises A/B, classifies each phase transition and
// maintains a wrapping position count with direction, step and error strobes.
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          clr,
  quad_decoder_if.slave bus
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             ab_prev_q, ab_prev_d;
  logic [PRIME_W-1:0]     prime_q, prime_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   m_q, m_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   err_flag_q, err_flag_d;

  logic [1:0] ab_s;
  logic       primed;
  logic       fwd, rev, bad;

  assign ab_s   = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign primed = (prime_q == PRIME_LAST);

  // Classify the previous->current synced phase pair (Gray-code walk).
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    bad = 1'b0;
    case ({ab_prev_q, ab_s})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
      default: ;
    endcase
  end

  // Next-state: sync shift, priming window, count/load and error tracking.
  always_comb begin
    a_sync_d   = {a_sync_q[SYNC_STAGES-2:0], bus.a};
    b_sync_d   = {b_sync_q[SYNC_STAGES-2:0], bus.b};
    ab_prev_d  = ab_s;
    prime_d    = prime_q;
    cnt_d      = cnt_q;
    m_d        = m_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    if (!primed) begin
      // Sync chain still holds reset/stale data: track it but never act on it.
      prime_d = prime_q + 1'b1;
    end else begin
      err_d = bad;
      if (bus.ld) begin
        cnt_d = bus.d;
      end else if (bus.en && fwd) begin
        cnt_d  = cnt_q + WIDTH'(1);
        m_d    = 1'b0;
        step_d = 1'b1;
      end else if (bus.en && rev) begin
        cnt_d  = cnt_q - WIDTH'(1);
        m_d    = 1'b1;
        step_d = 1'b1;
      end
    end
    // A fresh illegal transition outranks a clear request.
    if (err_d)            err_flag_d = 1'b1;
    else if (bus.clr_err) err_flag_d = 1'b0;
    else                  err_flag_d = err_flag_q;
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      a_sync_q   <= '0;
      b_sync_q   <= '0;
      ab_prev_q  <= '0;
      prime_q    <= '0;
      cnt_q      <= '0;
      m_q        <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      a_sync_q   <= a_sync_d;
      b_sync_q   <= b_sync_d;
      ab_prev_q  <= ab_prev_d;
      prime_q    <= prime_d;
      cnt_q      <= cnt_d;
      m_q        <= m_d;
      step_q     <= step_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus.q        = cnt_q;
  assign bus.m        = m_q;
  assign bus.step     = step_q;
  assign bus.err      = err_q;
  assign bus.err_flag = err_flag_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: vector table, corner-case sequences and random walk,
// every cycle checked against a phase-index reference model.
module tb_quad_decoder;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  quad_decoder_if #(.WIDTH(4)) bus ();

  quad_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int steps = 0;

  // Reference model state
  logic [1:0] p0 = 2'b00, p1 = 2'b00, p2 = 2'b00, p3 = 2'b00;
  int         mprime = 0;
  logic [3:0] mq = '0;
  logic       mm = 1'b0, ms = 1'b0, me = 1'b0, mf = 1'b0;

  typedef struct {
    logic       clr;
    logic [1:0] ab;
    logic       en;
    logic       ld;
    logic [3:0] d;
    logic       ce;
    int         cyc;
    logic [3:0] eq;
    logic       em;
    logic       ef;
    int         es;
  } vec_t;
  vec_t vt[$];

  function automatic int ph(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs applied before the edge,
  // then compare all DUT outputs shortly after the edge.
  task automatic tick();
    int dl;
    @(posedge clk);
    p3 = p2; p2 = p1; p1 = p0; p0 = {bus.a, bus.b};
    if (!clr) begin
      mq = '0; mm = 0; ms = 0; me = 0; mf = 0; mprime = 0;
    end else begin
      ms = 0; me = 0;
      if (mprime < 3) begin
        mprime++;
      end else begin
        dl = (ph(p2) - ph(p3) + 4) % 4;
        me = (dl == 2);
        if (bus.ld) mq = bus.d;
        else if (bus.en && dl == 1) begin mq = mq + 4'd1; mm = 0; ms = 1; end
        else if (bus.en && dl == 3) begin mq = mq - 4'd1; mm = 1; ms = 1; end
      end
      if (me) mf = 1;
      else if (bus.clr_err) mf = 0;
    end
    #1;
    check("outputs{q,m,step,err,flag}",
          {24'd0, bus.q, bus.m, bus.step, bus.err, bus.err_flag},
          {24'd0, mq, mm, ms, me, mf});
    if (bus.step) steps++;
  endtask

  task automatic drive(input logic c, input logic [1:0] ab, input logic en,
                       input logic ld, input logic [3:0] d, input logic ce);
    clr = c; bus.a = ab[1]; bus.b = ab[0];
    bus.en = en; bus.ld = ld; bus.d = d; bus.clr_err = ce;
  endtask

  function automatic vec_t mk(input logic c, input logic [1:0] ab, input logic en,
                              input logic ld, input logic [3:0] d, input logic ce,
                              input int cyc, input logic [3:0] eq, input logic em,
                              input logic ef, input int es);
    vec_t v;
    v.clr = c; v.ab = ab; v.en = en; v.ld = ld; v.d = d; v.ce = ce;
    v.cyc = cyc; v.eq = eq; v.em = em; v.ef = ef; v.es = es;
    return v;
  endfunction

  initial begin
    logic [1:0] fseq [4];
    logic [1:0] ab;
    fseq[0] = 2'b10; fseq[1] = 2'b11; fseq[2] = 2'b01; fseq[3] = 2'b00;

    // Reset/priming with phases at 11, then a clean reset at 00
    vt.push_back(mk(0, 2'b11, 1, 0, 0, 0, 2, 0, 0, 0, 0));
    vt.push_back(mk(1, 2'b11, 1, 0, 0, 0, 8, 0, 0, 0, 0));
    vt.push_back(mk(0, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 1, 0, 0, 0, 8, 0, 0, 0, 0));
    // Forward: four full cycles wrap 15 -> 0
    for (int k = 0; k < 16; k++)
      vt.push_back(mk(1, fseq[k % 4], 1, 0, 0, 0, 8, 4'((k + 1) % 16), 0, 0, 1));
    // Reverse with wrap below zero
    vt.push_back(mk(1, 2'b01, 1, 0, 0, 0, 8, 15, 1, 0, 1));
    vt.push_back(mk(1, 2'b11, 1, 0, 0, 0, 8, 14, 1, 0, 1));
    vt.push_back(mk(1, 2'b10, 1, 0, 0, 0, 8, 13, 1, 0, 1));
    vt.push_back(mk(1, 2'b00, 1, 0, 0, 0, 8, 12, 1, 0, 1));
    // Illegal 00 -> 11, then clear the sticky flag
    vt.push_back(mk(1, 2'b11, 1, 0, 0, 0, 8, 12, 1, 1, 0));
    vt.push_back(mk(1, 2'b11, 1, 0, 0, 1, 1, 12, 1, 0, 0));
    vt.push_back(mk(1, 2'b11, 1, 0, 0, 0, 4, 12, 1, 0, 0));
    // Enable low: four forward edges ignored, then one counted
    vt.push_back(mk(1, 2'b01, 0, 0, 0, 0, 8, 12, 1, 0, 0));
    vt.push_back(mk(1, 2'b00, 0, 0, 0, 0, 8, 12, 1, 0, 0));
    vt.push_back(mk(1, 2'b10, 0, 0, 0, 0, 8, 12, 1, 0, 0));
    vt.push_back(mk(1, 2'b11, 0, 0, 0, 0, 8, 12, 1, 0, 0));
    vt.push_back(mk(1, 2'b01, 1, 0, 0, 0, 8, 13, 0, 0, 1));
    // Load with phases steady
    vt.push_back(mk(1, 2'b01, 1, 1, 4'b1010, 0, 1, 10, 0, 0, 0));
    vt.push_back(mk(1, 2'b01, 1, 0, 0, 0, 4, 10, 0, 0, 0));

    drive(0, 2'b00, 1, 0, 0, 0);
    foreach (vt[i]) begin
      drive(vt[i].clr, vt[i].ab, vt[i].en, vt[i].ld, vt[i].d, vt[i].ce);
      steps = 0;
      for (int c = 0; c < vt[i].cyc; c++) tick();
      check($sformatf("vec%0d q", i), 32'(bus.q), 32'(vt[i].eq));
      check($sformatf("vec%0d m", i), 32'(bus.m), 32'(vt[i].em));
      check($sformatf("vec%0d err_flag", i), 32'(bus.err_flag), 32'(vt[i].ef));
      check($sformatf("vec%0d steps", i), 32'(steps), 32'(vt[i].es));
    end

    // Latency: pin edge reaches q/step on the third clock
    drive(1, 2'b00, 1, 0, 0, 0);
    tick(); check("lat step c1", 32'(bus.step), 0);
    tick(); check("lat step c2", 32'(bus.step), 0);
    tick(); check("lat step c3", 32'(bus.step), 1);
    check("lat q", 32'(bus.q), 11);
    repeat (5) tick();

    // Load coincident with a forward step: load wins, no step
    drive(1, 2'b10, 1, 0, 0, 0);
    tick(); tick();
    bus.ld = 1; bus.d = 4'd10;
    tick();
    check("ld+edge q", 32'(bus.q), 10);
    check("ld+edge step", 32'(bus.step), 0);
    check("ld+edge m", 32'(bus.m), 0);
    bus.ld = 0;
    repeat (5) tick();

    // clr_err coincident with an illegal transition: error wins
    drive(1, 2'b01, 1, 0, 0, 0);
    tick(); tick();
    bus.clr_err = 1;
    tick();
    check("ce+illegal err", 32'(bus.err), 1);
    check("ce+illegal flag", 32'(bus.err_flag), 1);
    bus.clr_err = 0;
    repeat (5) tick();
    check("flag sticky", 32'(bus.err_flag), 1);

    // Mid-run reset at q=7 with an edge in flight
    bus.ld = 1; bus.d = 4'd5; tick(); bus.ld = 0;
    bus.a = 0; bus.b = 0; repeat (4) tick();
    bus.a = 1; bus.b = 0; repeat (4) tick();
    check("pre-reset q", 32'(bus.q), 7);
    bus.a = 1; bus.b = 1; clr = 0;
    tick();
    clr = 1;
    check("mid reset q", 32'(bus.q), 0);
    check("mid reset m", 32'(bus.m), 0);
    check("mid reset flag", 32'(bus.err_flag), 0);
    steps = 0;
    repeat (8) tick();
    check("priming steps", 32'(steps), 0);
    check("priming q", 32'(bus.q), 0);
    bus.a = 0; bus.b = 1;
    repeat (5) tick();
    check("resume q", 32'(bus.q), 1);

    // Random walk against the model
    ab = 2'b01;
    for (int it = 0; it < 300; it++) begin
      int r, hold;
      r = int'($urandom_range(0, 15));
      if (r < 6)       ab = fseq[(ph(ab) + 0) % 4];
      else if (r < 11) ab = fseq[(ph(ab) + 2) % 4];
      else if (r == 11) ab = fseq[(ph(ab) + 1) % 4];
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 7));
      drive(($urandom_range(0, 39) != 0), ab,
            ($urandom_range(0, 5) != 0), ($urandom_range(0, 15) == 0),
            4'($urandom), ($urandom_range(0, 7) == 0));
      repeat (hold) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
